// File: rtl/seq_multiplier.sv
// Sequential shift-add unsigned multiplier: one partial product per clock,
// START/BUSY/DONE handshake, high/low half select and a chainable feedback register M.
module seq_multiplier #(
    parameter int W = 8
) (
    input  logic           CLK,
    input  logic           RST_N,
    input  logic           START,
    input  logic [W-1:0]   X,
    input  logic [W-1:0]   Y,
    input  logic           C,
    input  logic           F,
    input  logic           R,
    output logic [2*W-1:0] P,
    output logic [W-1:0]   Z,
    output logic [W-1:0]   M,
    output logic           BUSY,
    output logic           DONE
);

    localparam int CNT_W = $clog2(W);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]     state_q, state_d;
    logic [W-1:0]   a_q, a_d;
    logic [W-1:0]   b_q, b_d;
    logic [2*W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic           c_q, c_d;
    logic           f_q, f_d;
    logic [2*W-1:0] p_q, p_d;
    logic [W-1:0]   z_q, z_d;
    logic [W-1:0]   m_q, m_d;

    logic [W:0]     sum;
    logic [2*W-1:0] acc_step;
    logic [W-1:0]   half_sel;

    // The carry out of the upper-half add is kept as the new MSB, so no bit is lost.
    always_comb begin
        sum      = {1'b0, acc_q[2*W-1:W]} + {1'b0, (b_q[0] ? a_q : {W{1'b0}})};
        acc_step = {sum, acc_q[W-1:1]};
        half_sel = c_q ? acc_step[2*W-1:W] : acc_step[W-1:0];
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        c_d     = c_q;
        f_d     = f_q;
        p_d     = p_q;
        z_d     = z_q;
        m_d     = m_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (START) begin
                    // R selects the operand immediately; M here is the pre-edge value,
                    // which already includes a write from a completion in the prior cycle.
                    a_d     = X;
                    b_d     = R ? m_q : Y;
                    c_d     = C;
                    f_d     = F;
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = S_RUN;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                acc_d = acc_step;
                b_d   = b_q >> 1;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(W - 1)) begin
                    p_d     = acc_step;
                    z_d     = half_sel;
                    if (f_q) begin
                        m_d = half_sel;
                    end
                    state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            c_q     <= 1'b0;
            f_q     <= 1'b0;
            p_q     <= '0;
            z_q     <= '0;
            m_q     <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            c_q     <= c_d;
            f_q     <= f_d;
            p_q     <= p_d;
            z_q     <= z_d;
            m_q     <= m_d;
        end
    end

    assign P    = p_q;
    assign Z    = z_q;
    assign M    = m_q;
    assign BUSY = (state_q == S_RUN);
    assign DONE = (state_q == S_DONE);

endmodule

// File: tb/tb_seq_multiplier.sv
// Directed bench for seq_multiplier: W=8 and W=16 instances, hand-computed products,
// handshake timing, ignored START, feedback chaining and mid-run reset.
module tb_seq_multiplier;

    logic        CLK;
    logic        RST_N;

    logic        START8, C8, F8, R8;
    logic [7:0]  X8, Y8;
    logic [15:0] P8;
    logic [7:0]  Z8, M8;
    logic        BUSY8, DONE8;

    logic        START16, C16, F16, R16;
    logic [15:0] X16, Y16;
    logic [31:0] P16;
    logic [15:0] Z16, M16;
    logic        BUSY16, DONE16;

    int pass_cnt = 0;
    int fail_cnt = 0;

    seq_multiplier #(.W(8)) dut8 (
        .CLK(CLK), .RST_N(RST_N), .START(START8), .X(X8), .Y(Y8),
        .C(C8), .F(F8), .R(R8), .P(P8), .Z(Z8), .M(M8), .BUSY(BUSY8), .DONE(DONE8)
    );

    seq_multiplier #(.W(16)) dut16 (
        .CLK(CLK), .RST_N(RST_N), .START(START16), .X(X16), .Y(Y16),
        .C(C16), .F(F16), .R(R16), .P(P16), .Z(Z16), .M(M16), .BUSY(BUSY16), .DONE(DONE16)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        assert (obs === expv) begin
            pass_cnt++;
        end else begin
            fail_cnt++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Called at a negedge in IDLE or DONE; returns at the negedge where DONE is visible.
    task automatic run8(input string tag, input logic [7:0] x, input logic [7:0] y,
                        input logic c, input logic f, input logic r,
                        input logic [15:0] ep, input logic [7:0] ez, input logic [7:0] em);
        int n;
        X8 = x; Y8 = y; C8 = c; F8 = f; R8 = r; START8 = 1'b1;
        @(negedge CLK);
        START8 = 1'b0;
        X8 = 8'hA5; Y8 = 8'h5A; C8 = ~c; F8 = ~f; R8 = ~r;
        chk({tag, "_busy"}, 64'(BUSY8), 64'd1);
        n = 1;
        while (!DONE8 && n < 40) begin
            @(negedge CLK);
            n++;
        end
        chk({tag, "_done"}, 64'(DONE8), 64'd1);
        chk({tag, "_lat"}, 64'(n - 1), 64'd8);
        chk({tag, "_P"}, 64'(P8), 64'(ep));
        chk({tag, "_Z"}, 64'(Z8), 64'(ez));
        chk({tag, "_M"}, 64'(M8), 64'(em));
    endtask

    initial begin
        int n;
        int dones;
        logic [15:0] p_seen;
        logic [7:0]  z_seen;

        RST_N = 1'b0;
        START8 = 1'b0; X8 = '0; Y8 = '0; C8 = 1'b0; F8 = 1'b0; R8 = 1'b0;
        START16 = 1'b0; X16 = '0; Y16 = '0; C16 = 1'b0; F16 = 1'b0; R16 = 1'b0;
        repeat (3) @(negedge CLK);
        chk("rst_P", 64'(P8), 64'd0);
        chk("rst_Z", 64'(Z8), 64'd0);
        chk("rst_M", 64'(M8), 64'd0);
        chk("rst_BUSY", 64'(BUSY8), 64'd0);
        chk("rst_DONE", 64'(DONE8), 64'd0);
        RST_N = 1'b1;
        @(negedge CLK);

        run8("m1x11", 8'd1, 8'd11, 1'b0, 1'b0, 1'b0, 16'h000B, 8'h0B, 8'h00);
        @(negedge CLK);
        chk("m1x11_done_pulse", 64'(DONE8), 64'd0);
        chk("m1x11_busy_after", 64'(BUSY8), 64'd0);

        run8("m53x78_hi", 8'd53, 8'd78, 1'b1, 1'b1, 1'b0, 16'h1026, 8'h10, 8'h10);
        // back-to-back: issued in the DONE cycle
        run8("m53x78_lo", 8'd53, 8'd78, 1'b0, 1'b1, 1'b0, 16'h1026, 8'h26, 8'h26);
        run8("chain", 8'd53, 8'd200, 1'b0, 1'b0, 1'b1, 16'h07DE, 8'hDE, 8'h26);
        run8("m255", 8'd255, 8'd255, 1'b1, 1'b0, 1'b0, 16'hFE01, 8'hFE, 8'h26);
        run8("zero", 8'd0, 8'd77, 1'b0, 1'b0, 1'b0, 16'h0000, 8'h00, 8'h26);

        // START pulses during RUN must not disturb the operation in flight
        X8 = 8'd3; Y8 = 8'd5; C8 = 1'b0; F8 = 1'b0; R8 = 1'b0; START8 = 1'b1;
        @(negedge CLK);
        dones = 0; p_seen = '0; z_seen = '0;
        for (int i = 1; i <= 14; i++) begin
            START8 = (i == 2 || i == 5);
            if (START8) begin
                X8 = 8'd200; Y8 = 8'd100;
            end
            @(negedge CLK);
            if (DONE8) begin
                dones++;
                p_seen = P8;
                z_seen = Z8;
            end
        end
        START8 = 1'b0;
        chk("ign_dones", 64'(dones), 64'd1);
        chk("ign_P", 64'(p_seen), 64'h000F);
        chk("ign_Z", 64'(z_seen), 64'h0F);

        // Reset in the middle of a run discards the partial result
        X8 = 8'd9; Y8 = 8'd9; C8 = 1'b0; F8 = 1'b1; R8 = 1'b0; START8 = 1'b1;
        @(negedge CLK);
        START8 = 1'b0;
        repeat (3) @(negedge CLK);
        chk("mid_busy", 64'(BUSY8), 64'd1);
        RST_N = 1'b0;
        @(negedge CLK);
        RST_N = 1'b1;
        chk("mrst_P", 64'(P8), 64'd0);
        chk("mrst_Z", 64'(Z8), 64'd0);
        chk("mrst_M", 64'(M8), 64'd0);
        chk("mrst_BUSY", 64'(BUSY8), 64'd0);
        chk("mrst_DONE", 64'(DONE8), 64'd0);
        dones = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge CLK);
            if (DONE8) dones++;
        end
        chk("mrst_no_done", 64'(dones), 64'd0);
        chk("mrst_M_after", 64'(M8), 64'd0);

        // Wide instance
        X16 = 16'hFFFF; Y16 = 16'hFFFF; C16 = 1'b1; F16 = 1'b0; R16 = 1'b0; START16 = 1'b1;
        @(negedge CLK);
        START16 = 1'b0;
        chk("w16_busy", 64'(BUSY16), 64'd1);
        n = 1;
        while (!DONE16 && n < 60) begin
            @(negedge CLK);
            n++;
        end
        chk("w16_done", 64'(DONE16), 64'd1);
        chk("w16_lat", 64'(n - 1), 64'd16);
        chk("w16_P", 64'(P16), 64'hFFFE0001);
        chk("w16_Z", 64'(Z16), 64'hFFFE);

        $display("%0d/%0d checks passed", pass_cnt, pass_cnt + fail_cnt);
        $finish;
    end

endmodule
